// File: rtl/div_rate_switcher.sv
// div_rate_switcher
//   Glitch-free selectable clock-rate generator. A single 4-bit free-running
//   counter replaces the ripple /2../16 chain; rate changes are requested
//   with sel_valid/sel_ready and are applied only on the counter wrap
//   (15 -> 0), where every rate is phase-aligned.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   sel_in     in   requested rate, ratio = 2^(sel_in+1)
//   sel_valid  in   request present on sel_in
//   sel_ready  out  request can be accepted (state decode)
//   sel_done   out  one-cycle pulse: requested rate now active
//   cur_sel    out  rate currently in effect
//   div_clk    out  registered divided level, 50% duty
//   tick       out  registered one-cycle pulse per div_clk period
module div_rate_switcher #(
    parameter logic [1:0] RESET_SEL = 2'd3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] sel_in,
    input  logic       sel_valid,
    output logic       sel_ready,
    output logic       sel_done,
    output logic [1:0] cur_sel,
    output logic       div_clk,
    output logic       tick
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned SEL_W = 2;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SEL_W-1:0]   pend_sel_q, pend_sel_d;
    logic [SEL_W-1:0]   cur_sel_q, cur_sel_d;
    logic               div_clk_q, div_clk_d;
    logic               tick_q, tick_d;
    logic               sel_done_q, sel_done_d;
    logic               wrap_c;

    // This edge takes the counter 15 -> 0: all rates end a period together.
    assign wrap_c = (cnt_q == CNT_W'(15));

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:    if (sel_valid) state_d = ST_PENDING;
            ST_PENDING: if (wrap_c)    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // FSM output decode
    always_comb begin
        sel_ready = 1'b0;
        if (state_q == ST_IDLE) begin
            sel_ready = 1'b1;
        end
    end

    // Counter, request latch and rate switch
    always_comb begin
        cnt_d      = cnt_q + CNT_W'(1);
        pend_sel_d = pend_sel_q;
        cur_sel_d  = cur_sel_q;
        sel_done_d = 1'b0;
        if (state_q == ST_IDLE && sel_valid) begin
            pend_sel_d = sel_in;
        end
        // An acceptance on the wrap edge is in IDLE here, so it cannot switch
        // until the following wrap.
        if (state_q == ST_PENDING && wrap_c) begin
            cur_sel_d  = pend_sel_q;
            sel_done_d = 1'b1;
        end
    end

    // Divided level and tick from post-edge counter and selection
    always_comb begin
        div_clk_d = cnt_d[cur_sel_d];
        tick_d    = 1'b0;
        unique case (cur_sel_d)
            2'd0:    tick_d = cnt_d[0];
            2'd1:    tick_d = &cnt_d[1:0];
            2'd2:    tick_d = &cnt_d[2:0];
            default: tick_d = &cnt_d[3:0];
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            pend_sel_q <= '0;
            cur_sel_q  <= RESET_SEL;
            div_clk_q  <= 1'b0;
            tick_q     <= 1'b0;
            sel_done_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            pend_sel_q <= pend_sel_d;
            cur_sel_q  <= cur_sel_d;
            div_clk_q  <= div_clk_d;
            tick_q     <= tick_d;
            sel_done_q <= sel_done_d;
        end
    end

    assign cur_sel  = cur_sel_q;
    assign div_clk  = div_clk_q;
    assign tick     = tick_q;
    assign sel_done = sel_done_q;

endmodule

// File: tb/tb_div_rate_switcher.sv
// tb_div_rate_switcher
//   Directed bench for div_rate_switcher. A bench-side counter (ecnt) tracks
//   the expected counter phase; expected waveforms are written per rate.
module tb_div_rate_switcher;

    logic       clk;
    logic       rst;
    logic [1:0] sel_in;
    logic       sel_valid;
    logic       sel_ready;
    logic       sel_done;
    logic [1:0] cur_sel;
    logic       div_clk;
    logic       tick;

    logic [3:0] ecnt;
    int         n_checks;
    int         n_pass;

    div_rate_switcher #(.RESET_SEL(2'd3)) dut (
        .clk       (clk),
        .rst       (rst),
        .sel_in    (sel_in),
        .sel_valid (sel_valid),
        .sel_ready (sel_ready),
        .sel_done  (sel_done),
        .cur_sel   (cur_sel),
        .div_clk   (div_clk),
        .tick      (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1);
    end

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic cycle();
        @(posedge clk);
        if (rst) ecnt = 4'd0;
        else     ecnt = ecnt + 4'd1;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; sel_valid = 1'b0; sel_in = 2'd0; ecnt = 4'd0;
        repeat (2) cycle();
        n_checks++; if (sel_ready !== 1'b1) $display("FAIL rst_ready got %b exp 1", sel_ready); else n_pass++;
        n_checks++; if (cur_sel !== 2'd3) $display("FAIL rst_cur_sel got %0d exp 3", cur_sel); else n_pass++;
        n_checks++; if (div_clk !== 1'b0) $display("FAIL rst_div_clk got %b exp 0", div_clk); else n_pass++;
        n_checks++; if (tick !== 1'b0) $display("FAIL rst_tick got %b exp 0", tick); else n_pass++;
        n_checks++; if (sel_done !== 1'b0) $display("FAIL rst_done got %b exp 0", sel_done); else n_pass++;
        rst = 1'b0;
        for (int i = 0; i < 48; i++) begin
            cycle();
            n_checks++; if (div_clk !== (ecnt >= 4'd8)) $display("FAIL div16_level cnt=%0d got %b exp %b", ecnt, div_clk, (ecnt >= 4'd8)); else n_pass++;
            n_checks++; if (tick !== (ecnt == 4'd15)) $display("FAIL div16_tick cnt=%0d got %b exp %b", ecnt, tick, (ecnt == 4'd15)); else n_pass++;
            n_checks++; if (cur_sel !== 2'd3 || sel_ready !== 1'b1 || sel_done !== 1'b0)
                $display("FAIL idle_status cnt=%0d got sel=%0d rdy=%b done=%b exp 3/1/0", ecnt, cur_sel, sel_ready, sel_done); else n_pass++;
        end
    endtask

    task automatic test_mid_switch();
        while (ecnt != 4'd3) cycle();
        sel_valid = 1'b1; sel_in = 2'd0;
        cycle();
        sel_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            n_checks++; if (sel_ready !== 1'b0 || cur_sel !== 2'd3 || sel_done !== 1'b0)
                $display("FAIL pending_status cnt=%0d got rdy=%b sel=%0d done=%b exp 0/3/0", ecnt, sel_ready, cur_sel, sel_done); else n_pass++;
            if (i < 11) cycle();
        end
        cycle();
        n_checks++; if (cur_sel !== 2'd0) $display("FAIL switch_sel0 got %0d exp 0", cur_sel); else n_pass++;
        n_checks++; if (sel_done !== 1'b1) $display("FAIL switch_done0 got %b exp 1", sel_done); else n_pass++;
        n_checks++; if (sel_ready !== 1'b1) $display("FAIL switch_ready0 got %b exp 1", sel_ready); else n_pass++;
        n_checks++; if (div_clk !== 1'b0 || tick !== 1'b0) $display("FAIL switch_glitch0 got div=%b tick=%b exp 0/0", div_clk, tick); else n_pass++;
        for (int i = 0; i < 16; i++) begin
            cycle();
            n_checks++; if (div_clk !== ecnt[0]) $display("FAIL div2_level cnt=%0d got %b exp %b", ecnt, div_clk, ecnt[0]); else n_pass++;
            n_checks++; if (tick !== ecnt[0]) $display("FAIL div2_tick cnt=%0d got %b exp %b", ecnt, tick, ecnt[0]); else n_pass++;
            n_checks++; if (sel_done !== 1'b0) $display("FAIL div2_done cnt=%0d got %b exp 0", ecnt, sel_done); else n_pass++;
        end
    endtask

    task automatic test_accept_on_wrap();
        while (ecnt != 4'd15) cycle();
        sel_valid = 1'b1; sel_in = 2'd1;
        cycle();
        sel_valid = 1'b0;
        n_checks++; if (cur_sel !== 2'd0 || sel_done !== 1'b0 || sel_ready !== 1'b0)
            $display("FAIL wrap_accept got sel=%0d done=%b rdy=%b exp 0/0/0", cur_sel, sel_done, sel_ready); else n_pass++;
        for (int i = 0; i < 15; i++) begin
            cycle();
            n_checks++; if (cur_sel !== 2'd0 || sel_ready !== 1'b0 || sel_done !== 1'b0 || div_clk !== ecnt[0])
                $display("FAIL wrap_wait cnt=%0d got sel=%0d rdy=%b done=%b div=%b", ecnt, cur_sel, sel_ready, sel_done, div_clk); else n_pass++;
        end
        cycle();
        n_checks++; if (cur_sel !== 2'd1 || sel_done !== 1'b1) $display("FAIL wrap_switch got sel=%0d done=%b exp 1/1", cur_sel, sel_done); else n_pass++;
        for (int i = 0; i < 16; i++) begin
            cycle();
            n_checks++; if (tick !== (ecnt[1:0] == 2'd3)) $display("FAIL div4_tick cnt=%0d got %b exp %b", ecnt, tick, (ecnt[1:0] == 2'd3)); else n_pass++;
            n_checks++; if (div_clk !== ecnt[1]) $display("FAIL div4_level cnt=%0d got %b exp %b", ecnt, div_clk, ecnt[1]); else n_pass++;
        end
    endtask

    task automatic test_ignore_while_pending();
        while (ecnt != 4'd4) cycle();
        sel_valid = 1'b1; sel_in = 2'd2;
        cycle();
        sel_in = 2'd1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            n_checks++; if (sel_ready !== 1'b0) $display("FAIL ignore_ready cnt=%0d got %b exp 0", ecnt, sel_ready); else n_pass++;
        end
        sel_valid = 1'b0;
        while (ecnt != 4'd15) begin
            cycle();
            n_checks++; if (sel_done !== 1'b0) $display("FAIL ignore_early_done cnt=%0d got %b exp 0", ecnt, sel_done); else n_pass++;
        end
        cycle();
        n_checks++; if (cur_sel !== 2'd2 || sel_done !== 1'b1) $display("FAIL ignore_switch got sel=%0d done=%b exp 2/1", cur_sel, sel_done); else n_pass++;
        for (int i = 0; i < 16; i++) begin
            cycle();
            n_checks++; if (sel_done !== 1'b0 || cur_sel !== 2'd2) $display("FAIL ignore_after cnt=%0d got done=%b sel=%0d exp 0/2", ecnt, sel_done, cur_sel); else n_pass++;
            n_checks++; if (tick !== (ecnt[2:0] == 3'd7) || div_clk !== ecnt[2])
                $display("FAIL div8_wave cnt=%0d got tick=%b div=%b exp %b/%b", ecnt, tick, div_clk, (ecnt[2:0] == 3'd7), ecnt[2]); else n_pass++;
        end
    endtask

    task automatic test_reset_pending();
        while (ecnt != 4'd7) cycle();
        sel_valid = 1'b1; sel_in = 2'd0;
        cycle();
        sel_valid = 1'b0;
        cycle();
        n_checks++; if (sel_ready !== 1'b0) $display("FAIL rp_pending got %b exp 0", sel_ready); else n_pass++;
        rst = 1'b1;
        #1;
        ecnt = 4'd0;
        n_checks++; if (cur_sel !== 2'd3 || div_clk !== 1'b0 || tick !== 1'b0 || sel_ready !== 1'b1 || sel_done !== 1'b0)
            $display("FAIL rp_async got sel=%0d div=%b tick=%b rdy=%b done=%b exp 3/0/0/1/0", cur_sel, div_clk, tick, sel_ready, sel_done); else n_pass++;
        cycle();
        rst = 1'b0;
        n_checks++; if (sel_ready !== 1'b1) $display("FAIL rp_ready got %b exp 1", sel_ready); else n_pass++;
        for (int i = 0; i < 32; i++) begin
            cycle();
            n_checks++; if (sel_done !== 1'b0 || cur_sel !== 2'd3) $display("FAIL rp_no_done cnt=%0d got done=%b sel=%0d exp 0/3", ecnt, sel_done, cur_sel); else n_pass++;
            n_checks++; if (div_clk !== (ecnt >= 4'd8) || tick !== (ecnt == 4'd15))
                $display("FAIL rp_wave cnt=%0d got div=%b tick=%b", ecnt, div_clk, tick); else n_pass++;
        end
    endtask

    task automatic test_same_sel();
        while (ecnt != 4'd2) cycle();
        sel_valid = 1'b1; sel_in = 2'd3;
        cycle();
        sel_valid = 1'b0;
        for (int i = 0; i < 32; i++) begin
            cycle();
            n_checks++; if (div_clk !== (ecnt >= 4'd8) || tick !== (ecnt == 4'd15) || cur_sel !== 2'd3)
                $display("FAIL same_wave cnt=%0d got div=%b tick=%b sel=%0d", ecnt, div_clk, tick, cur_sel); else n_pass++;
            n_checks++; if (sel_done !== (ecnt == 4'd0 && i < 16)) $display("FAIL same_done i=%0d got %b exp %b", i, sel_done, (ecnt == 4'd0 && i < 16)); else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        while (ecnt != 4'd5) cycle();
        sel_valid = 1'b1; sel_in = 2'd1;
        cycle();
        sel_valid = 1'b0;
        while (ecnt != 4'd0) cycle();
        n_checks++; if (sel_done !== 1'b1 || sel_ready !== 1'b1 || cur_sel !== 2'd1)
            $display("FAIL b2b_first got done=%b rdy=%b sel=%0d exp 1/1/1", sel_done, sel_ready, cur_sel); else n_pass++;
        sel_valid = 1'b1; sel_in = 2'd0;
        cycle();
        sel_valid = 1'b0;
        n_checks++; if (sel_ready !== 1'b0 || sel_done !== 1'b0 || cur_sel !== 2'd1)
            $display("FAIL b2b_accept got rdy=%b done=%b sel=%0d exp 0/0/1", sel_ready, sel_done, cur_sel); else n_pass++;
        while (ecnt != 4'd15) cycle();
        cycle();
        n_checks++; if (cur_sel !== 2'd0 || sel_done !== 1'b1) $display("FAIL b2b_switch got sel=%0d done=%b exp 0/1", cur_sel, sel_done); else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        test_reset();
        test_mid_switch();
        test_accept_on_wrap();
        test_ignore_while_pending();
        test_reset_pending();
        test_same_sel();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
